// File: rtl/uart_rx_serial.sv
// uart_rx_serial: 8N1 UART receiver with mid-bit sampling, framing-error detection and break lockout
module uart_rx_serial #(
   parameter int CLOCKS_POR_BIT = 5209
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       bitSerialRecebido,
   output logic [7:0] byteRecebido,
   output logic       dadosValidos,
   output logic       erroDeQuadro,
   output logic       recepcaoEmAndamento
);
   localparam int CW = (CLOCKS_POR_BIT > 1) ? $clog2(CLOCKS_POR_BIT) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(CLOCKS_POR_BIT - 1);
   localparam logic [CW-1:0] MEIO = CW'((CLOCKS_POR_BIT - 1) / 2);
   localparam logic [2:0] ESPERA = 3'd0;
   localparam logic [2:0] BIT_INICIO = 3'd1;
   localparam logic [2:0] BITS_DADOS = 3'd2;
   localparam logic [2:0] BIT_PARADA = 3'd3;
   localparam logic [2:0] LIMPEZA = 3'd4;
   logic [2:0] estado;
   logic [CW-1:0] contador;
   logic [2:0] indiceBit;
   logic [7:0] deslocamento;
   logic linhaMeta, linhaSinc, armado;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         linhaMeta <= 1'b1;
         linhaSinc <= 1'b1;
      end else begin
         linhaMeta <= bitSerialRecebido;
         linhaSinc <= linhaMeta;
      end
   // armado is cleared by a framing error so a held-low line cannot start new frames
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         estado <= ESPERA;
         contador <= '0;
         indiceBit <= '0;
         deslocamento <= '0;
         armado <= 1'b1;
         byteRecebido <= '0;
         dadosValidos <= 1'b0;
         erroDeQuadro <= 1'b0;
         recepcaoEmAndamento <= 1'b0;
      end else begin
         dadosValidos <= 1'b0;
         erroDeQuadro <= 1'b0;
         case (estado)
            ESPERA: begin
               contador <= '0;
               indiceBit <= '0;
               if (linhaSinc) armado <= 1'b1;
               else if (armado) begin
                  estado <= BIT_INICIO;
                  recepcaoEmAndamento <= 1'b1;
               end
            end
            BIT_INICIO:
               if (contador == MEIO) begin
                  contador <= '0;
                  if (linhaSinc) begin
                     estado <= ESPERA;
                     recepcaoEmAndamento <= 1'b0;
                  end else estado <= BITS_DADOS;
               end else contador <= contador + CW'(1);
            BITS_DADOS:
               if (contador == ULTIMO) begin
                  contador <= '0;
                  deslocamento[indiceBit] <= linhaSinc;
                  if (indiceBit == 3'd7) estado <= BIT_PARADA;
                  else indiceBit <= indiceBit + 3'd1;
               end else contador <= contador + CW'(1);
            BIT_PARADA:
               if (contador == ULTIMO) begin
                  contador <= '0;
                  estado <= LIMPEZA;
                  if (linhaSinc) begin
                     byteRecebido <= deslocamento;
                     dadosValidos <= 1'b1;
                  end else begin
                     erroDeQuadro <= 1'b1;
                     armado <= 1'b0;
                  end
               end else contador <= contador + CW'(1);
            LIMPEZA: begin
               recepcaoEmAndamento <= 1'b0;
               estado <= ESPERA;
            end
            default: estado <= ESPERA;
         endcase
      end
endmodule

// File: doc/uart_rx_serial.md
UART_RX_SERIAL -- requirements
Module: uart_rx_serial

Interface
REQ-001 The block SHALL have one parameter: CLOCKS_POR_BIT, default 5209, which sets the number of clock cycles per bit (50 MHz / 9600 baud); the minimum legal value is 4.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clock  input  1  single clock, all logic on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- bitSerialRecebido  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
- byteRecebido  output  8  last correctly framed byte; holds its value until the next valid frame.
- dadosValidos  output  1  one-cycle pulse when byteRecebido is updated.
- erroDeQuadro  output  1  one-cycle pulse when the stop bit is sampled low.
- recepcaoEmAndamento  output  1  high from start-bit detection until return to idle.

Function
REQ-003 bitSerialRecebido SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (linhaSinc).
REQ-004 The bit-period counter SHALL be at least ceil(log2(CLOCKS_POR_BIT)) bits wide and SHALL never exceed CLOCKS_POR_BIT-1.
REQ-005 The state machine SHALL have these states: ESPERA, BIT_INICIO, BITS_DADOS, BIT_PARADA, LIMPEZA.
REQ-006 In ESPERA:
- counter = 0; bit index = 0.
- When linhaSinc = 0 and armado = 1, go to BIT_INICIO and set recepcaoEmAndamento = 1.
REQ-007 In BIT_INICIO, the block counts to (CLOCKS_POR_BIT-1)/2 (integer division) and then samples linhaSinc:
- Sample = 0: clear the counter and go to BITS_DADOS.
- Sample = 1: glitch. Go to ESPERA, clear recepcaoEmAndamento, and pulse neither dadosValidos nor erroDeQuadro.
REQ-008 In BITS_DADOS, each bit is sampled when the counter reaches CLOCKS_POR_BIT-1, then the counter clears:
- Sample i (i = 0..7) goes to shift register bit i.
- After bit 7, go to BIT_PARADA.
REQ-009 In BIT_PARADA, the block samples at counter = CLOCKS_POR_BIT-1:
- Sample = 1: on the next edge, load byteRecebido from the shift register and pulse dadosValidos for one cycle.
- Sample = 0: byteRecebido is unchanged; pulse erroDeQuadro for one cycle and clear armado.
- In both cases, go to LIMPEZA.
REQ-010 LIMPEZA SHALL last one cycle: clear recepcaoEmAndamento and go to ESPERA.
REQ-011 armado SHALL be set whenever linhaSinc = 1 while in ESPERA, so a break (line held low) after a framing error produces no further frames until the line returns high.
REQ-012 dadosValidos and erroDeQuadro SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-013 Back-to-back frames (a start bit immediately after the stop-bit sample) SHALL be received without loss. LIMPEZA plus the half-bit start sampling absorbs the delay.
REQ-014 Line changes that occur while the block is not in ESPERA or BIT_INICIO SHALL affect only the bit being sampled.
REQ-015 Latency: the start sample occurs (CLOCKS_POR_BIT-1)/2 + 3 cycles after the line falls at the pin, and each later sample occurs CLOCKS_POR_BIT cycles after the previous one.

Reset
REQ-016 While reset_n = 0, the block SHALL hold:
- state = ESPERA; counters = 0; shift register = 0; armado = 1.
- synchronizer flops = 1.
- byteRecebido = 8'h00; dadosValidos = erroDeQuadro = recepcaoEmAndamento = 0.
REQ-017 Reset asserted mid-frame SHALL abort the frame with no pulse. After release, reception SHALL resume at the next falling edge seen in ESPERA.

Verification (CLOCKS_POR_BIT = 16 unless stated)
REQ-018 Send 8'hA5 with 8N1 at 16 clocks per bit -> byteRecebido = 8'hA5; one dadosValidos pulse; no erroDeQuadro; recepcaoEmAndamento returns to 0.
REQ-019 Send 8'h00, 8'hFF and 8'h3C back-to-back with no idle gap -> three dadosValidos pulses with values 00, FF, 3C in order.
REQ-020 Pulse the line low for 4 clocks, then hold it high -> no pulse on either output; byteRecebido unchanged; recepcaoEmAndamento high at most (16-1)/2+1 cycles.
REQ-021 Send 8'h55 with the stop bit forced low, then hold the line low for 30 bit times, then idle high, then send 8'h81 -> one erroDeQuadro pulse, byteRecebido stays at its prior value during the break, then dadosValidos with 8'h81.
REQ-022 Assert reset_n = 0 during data bit 4 of 8'hC3, release it, then send 8'h7E -> no pulse for the aborted frame; byteRecebido = 8'h7E after the second frame.
REQ-023 With CLOCKS_POR_BIT = 5209, send 8'h5A while the transmitter bit period is off by ±2% -> byteRecebido = 8'h5A with dadosValidos.
